instr_fetch_unit: RTL and testbench

//  Instruction-fetch front end that sits directly upstream of the processor datapath. It owns the PC
//  and issues in-order word fetches to instruction memory over a valid/ready request channel.

---
 rtl/instr_fetch_unit_if.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundles the fetch unit's handshake signals: redirect, the
//               instruction-memory request/response channels and the decode
//               side instruction queue output.
//               master = fetch unit side, slave = memory/decode environment.
// Ports       : redirect_valid/redirect_pc                 (env -> fetch)
//               imem_req_valid/imem_req_addr               (fetch -> mem)
//               imem_req_ready                             (mem -> fetch)
//               imem_rsp_valid/imem_rsp_data               (mem -> fetch)
//               instr_valid/instr/instr_pc                 (fetch -> decode)
//               instr_ready                                (decode -> fetch)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction-fetch front end. Owns the PC, issues in-order word
//               fetches under a credit limit, buffers variable-latency
//               responses in a DEPTH-entry queue tagged with their PC, and
//               flushes/squashes on redirect.
// Ports       : clk   - clock, all state on rising edge
//               reset - asynchronous, active-low reset
//               bus   - instr_fetch_unit_if.master (redirect, imem request,
//                       imem response, instruction output channels)
// Parameters  : RESET_PC - PC of the first fetch after reset release
//               DEPTH    - queue entries, power of 2, >= 2
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_unit_if.master     bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   C_DEPTH_WIDE = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic          run_q;                    // low during reset, high once released
  logic [31:0]   fetch_pc_q,  fetch_pc_d;
  logic [CW-1:0] out_q,       out_d;       // requests accepted, response pending
  logic [CW-1:0] disc_q,      disc_d;      // pending responses that are stale
  logic [CW-1:0] occ_q,       occ_d;       // instruction queue occupancy
  logic [AW-1:0] q_rd_q,      q_rd_d;
  logic [AW-1:0] q_wr_q,      q_wr_d;
  logic [AW-1:0] tag_rd_q,    tag_rd_d;
  logic [AW-1:0] tag_wr_q,    tag_wr_d;

  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   q_pc_q    [DEPTH];
  logic [31:0]   tag_pc_q  [DEPTH];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic credit_ok;
  logic req_hs;
  logic rsp;
  logic keep;
  logic pop;
  logic redirect;
  logic unused_pc_lsbs;

  // Credit counts stale in-flight requests too, so every response that is
  // kept is guaranteed a free queue slot. Depends on registers only.
  assign credit_ok = ({1'b0, occ_q} + {1'b0, out_q}) < C_DEPTH_WIDE;

  assign redirect       = bus.redirect_valid;
  assign req_hs         = run_q & credit_ok & bus.imem_req_ready;
  assign rsp            = bus.imem_rsp_valid;
  assign keep           = rsp & (disc_q == '0) & ~redirect;
  assign pop            = (occ_q != '0) & bus.instr_ready & ~redirect;
  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    disc_d     = disc_q;
    occ_d      = occ_q;
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    // Outstanding tracks real bus traffic, redirect or not.
    out_d = out_q + CW'(req_hs) - CW'(rsp);

    if (redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      // Everything still in flight after this cycle is stale, including a
      // request accepted right now; a response arriving now is dropped here.
      disc_d     = out_d;
      occ_d      = '0;
      q_rd_d     = '0;
      q_wr_d     = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        tag_wr_d   = tag_wr_q + 1'b1;
      end
      // Stale responses never had a tag (tags were flushed), so only kept
      // responses consume one.
      if (rsp && (disc_q != '0)) begin
        disc_d = disc_q - 1'b1;
      end
      if (keep) begin
        q_wr_d   = q_wr_q + 1'b1;
        tag_rd_d = tag_rd_q + 1'b1;
      end
      if (pop) begin
        q_rd_d = q_rd_q + 1'b1;
      end
      occ_d = occ_q + CW'(keep) - CW'(pop);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      occ_q      <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
        tag_pc_q[i]  <= '0;
      end
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      occ_q      <= occ_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      if (req_hs && !redirect) begin
        tag_pc_q[tag_wr_q] <= fetch_pc_q;
      end
      if (keep) begin
        q_instr_q[q_wr_q] <= bus.imem_rsp_data;
        q_pc_q[q_wr_q]    <= tag_pc_q[tag_rd_q];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.imem_req_valid = run_q & credit_ok;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = (occ_q != '0);
  // Head entry shown unconditionally; meaningless while instr_valid is low.
  assign bus.instr          = q_instr_q[q_rd_q];
  assign bus.instr_pc       = q_pc_q[q_rd_q];

  // --------------------------------------------------------------------------
  // Overflow / underflow checks
  // --------------------------------------------------------------------------
  a_rsp_underflow: assert property (@(posedge clk) disable iff (!reset)
    rsp |-> (out_q != '0));
  a_queue_overflow: assert property (@(posedge clk) disable iff (!reset)
    keep |-> (occ_q < C_DEPTH));
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    (out_q <= C_DEPTH) && (occ_q <= C_DEPTH) && (disc_q <= out_q));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A queue-level model
//               (fetch PC, in-flight count, stale count, queue of PCs held)
//               predicts the outputs every cycle; a memory responder returns
//               hashed data for each accepted address, in order, with
//               configurable latency. Directed scenarios pin the model with
//               literal expectations, then a long randomized run follows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int p_ready = 100;
  int p_iready = 100;
  int lat_lo = 1;
  int lat_hi = 1;

  // Model state
  logic [31:0] m_fetch_pc;
  int          m_out;
  int          m_disc;
  logic [31:0] m_q[$];
  logic [31:0] m_tags[$];

  // Memory responder state
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  // Observed DUT handshakes, for the directed literal checks
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.instr_ready    = 1'b0;
  endtask

  task automatic model_reset();
    m_fetch_pc = RESET_PC;
    m_out      = 0;
    m_disc     = 0;
    m_q.delete();
    m_tags.delete();
    pend_addr.delete();
    pend_due.delete();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_log.delete();
  endtask

  // Asserts reset off any clock edge and checks the asynchronous reset values.
  task automatic apply_reset();
    #1;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_req_valid",   32'(bus.imem_req_valid), 32'h0);
    chk("rst_req_addr",    bus.imem_req_addr, RESET_PC);
    chk("rst_instr",       bus.instr, 32'h0);
    chk("rst_instr_pc",    bus.instr_pc, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model by what happens at the coming rising edge.
  task automatic step(input logic redir = 1'b0, input logic [31:0] rpc = 32'h0);
    bit          rdy, ird, rv, hs, pop, exp_v, exp_rv;
    logic [31:0] rdata;
    int          due;
    @(negedge clk);
    rdy   = ($urandom_range(99) < p_ready);
    ird   = ($urandom_range(99) < p_iready);
    rv    = (pend_due.size() > 0) && (pend_due[0] <= cyc);
    rdata = rv ? memf(pend_addr[0]) : $urandom;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rdata;
    bus.instr_ready    = ird;
    #1;

    exp_v  = (m_q.size() > 0);
    exp_rv = ((m_q.size() + m_out) < DEPTH);
    chk("instr_valid", 32'(bus.instr_valid), 32'(exp_v));
    if (exp_v) begin
      chk("instr_pc", bus.instr_pc, m_q[0]);
      chk("instr",    bus.instr,    memf(m_q[0]));
    end
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    chk("req_addr",  bus.imem_req_addr, m_fetch_pc);

    if (!redir && bus.imem_req_valid && rdy) req_log.push_back(bus.imem_req_addr);
    if (!redir && bus.instr_valid && ird)    pop_log.push_back(bus.instr_pc);

    hs  = exp_rv && rdy;
    pop = exp_v && ird;

    // Memory side: every accepted request is answered, stale or not, in order.
    if (rv) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (hs) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (pend_due.size() > 0 && pend_due[$] >= due) due = pend_due[$] + 1;
      pend_addr.push_back(m_fetch_pc);
      pend_due.push_back(due);
    end

    if (redir) begin
      m_out      = m_out + int'(hs) - int'(rv);
      m_disc     = m_out;
      m_q.delete();
      m_tags.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rv) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else if (m_tags.size() > 0) m_q.push_back(m_tags.pop_front());
      end
      if (hs) begin
        m_tags.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_out++;
      end
    end
    cyc++;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int wraps;
    reset = 1'b0;
    idle_inputs();

    // ---------------- Test 1: free-flowing fetch ----------------
    p_ready = 100; p_iready = 100; lat_lo = 1; lat_hi = 1;
    apply_reset();
    clear_logs();
    step();
    chk("t1_first_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("t1_first_addr", bus.imem_req_addr, 32'h0);
    step();
    chk("t1_not_yet_valid", 32'(bus.instr_valid), 32'h0);
    step();
    chk("t1_first_valid", 32'(bus.instr_valid), 32'h1);
    chk("t1_first_pc", bus.instr_pc, 32'h0);
    repeat (20) step();
    chk("t1_req3_addr", req_log[3], 32'h0000_000C);
    chk("t1_pop5_pc",   pop_log[5], 32'h0000_0014);

    // ---------------- Test 2: consumer stalled ----------------
    apply_reset();
    clear_logs();
    p_iready = 0;
    repeat (10) step();
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_req_valid_low", 32'(bus.imem_req_valid), 32'h0);
    p_iready = 100;
    g = 0;
    while ((pop_log.size() < 4 || req_log.size() < 5) && g < 50) begin
      step();
      g++;
    end
    if (g >= 50) timeout("t2_drain");
    else begin
      chk("t2_pop0", pop_log[0], 32'h0);
      chk("t2_pop1", pop_log[1], 32'h4);
      chk("t2_pop2", pop_log[2], 32'h8);
      chk("t2_pop3", pop_log[3], 32'hC);
      chk("t2_resume_addr", req_log[4], 32'h10);
    end

    // ---------------- Test 3: redirect with 2 in flight ----------------
    apply_reset();
    p_iready = 100; lat_lo = 3; lat_hi = 3;
    step();
    step();
    p_ready = 0;
    step(1'b1, 32'h0000_0103);
    clear_logs();
    p_ready = 100;
    step();
    chk("t3_addr_after_redirect", bus.imem_req_addr, 32'h100);
    g = 0;
    while (pop_log.size() < 1 && g < 40) begin
      step();
      g++;
    end
    if (g >= 40) timeout("t3_first_pop");
    else begin
      chk("t3_first_req", req_log[0], 32'h100);
      chk("t3_first_pop", pop_log[0], 32'h100);
    end

    // ---------------- Test 4: redirect with rsp + req + pop ----------------
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    clear_logs();
    step(1'b1, 32'h2000_0042);
    step();
    chk("t4_empty_after_redirect", 32'(bus.instr_valid), 32'h0);
    g = 0;
    while (pop_log.size() < 1 && g < 40) begin
      step();
      g++;
    end
    if (g >= 40) timeout("t4_first_pop");
    else begin
      chk("t4_first_req", req_log[0], 32'h2000_0040);
      chk("t4_first_pop", pop_log[0], 32'h2000_0040);
    end

    // ---------------- Test 5: reset mid-operation ----------------
    apply_reset();
    p_iready = 0;
    repeat (4) step();
    @(posedge clk);
    #1;
    chk("t5_pre_valid", 32'(bus.instr_valid), 32'h1);
    chk("t5_pre_req_valid", 32'(bus.imem_req_valid), 32'h0);
    apply_reset();
    clear_logs();
    p_iready = 100;
    g = 0;
    while (pop_log.size() < 1 && g < 40) begin
      step();
      g++;
    end
    if (g >= 40) timeout("t5_restart");
    else begin
      chk("t5_restart_req", req_log[0], RESET_PC);
      chk("t5_restart_pop", pop_log[0], RESET_PC);
    end

    // ---------------- Test 6: randomized, PC wrap ----------------
    apply_reset();
    p_ready = 70; p_iready = 60; lat_lo = 1; lat_hi = 5;
    step(1'b1, 32'hFFFF_FFF1);
    clear_logs();
    g = 0;
    while (pop_log.size() < 1000 && g < 20000) begin
      if ($urandom_range(199) == 0) step(1'b1, 32'hFFFF_FF00 | 32'($urandom_range(255)));
      else step();
      g++;
    end
    if (g >= 20000) timeout("t6_1000_instrs");
    chk("t6_first_pop", pop_log[0], 32'hFFFF_FFF0);
    wraps = 0;
    foreach (pop_log[i]) if (pop_log[i] == 32'h0) wraps++;
    chk("t6_wrap_seen", 32'(wraps > 0), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
